// File: rtl/phase_responder_pkg.sv
// Shared definitions for the phase responder.
// Holds the FSM state encoding, the internal operation tags that remember
// which kind of memory access is in flight, the instruction-register field
// positions and the default halt opcode.
package phase_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

  // What the responder is doing while in MEM_WAIT. OP_NONE covers the phases
  // that complete without touching memory; they still pass through MEM_WAIT
  // so that done lands two cycles after the phase pulse.
  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_FETCH   = 3'd1,
    OP_OPERAND = 3'd2,
    OP_DATA_RD = 3'd3,
    OP_DATA_WR = 3'd4
  } op_t;

  // Instruction-register fields.
  localparam int CNT_HI  = 7;  // execute phase count code, ir[7:6]
  localparam int CNT_LO  = 6;
  localparam int MEM_BIT = 5;  // 1 = instruction accesses memory
  localparam int WE_BIT  = 4;  // 1 = memory access is a write

  localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;

endpackage

// File: rtl/phase_responder_mem_port.sv
// Memory port of the phase responder.
// Owns the request/address/write-enable/write-data registers, recognises the
// acknowledge and runs the acknowledge timeout counter.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               launch a request this cycle (only while idle)
//   start_we/addr/wdata attributes of the request being launched
//   mem_ack             one-cycle acknowledge from memory
//   mem_req/we/addr/wdata  registered request to memory
//   hit                 acknowledge accepted this cycle (request was open)
//   timeout             last allowed wait cycle expired without acknowledge
module phase_responder_mem_port
  import phase_responder_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              hit,
  output logic              timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // An acknowledge only counts while a request is open; stray acks are dropped.
  assign hit     = mem_req & mem_ack;
  // An ack in the final allowed cycle still wins over the timeout.
  assign timeout = mem_req & ~mem_ack & (wait_cnt == LAST_WAIT);

  // NOTE: reset is sampled synchronously inside the clocked block, so it
  // drops mem_req on the very edge it is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= start_we;
      mem_addr  <= start_addr;
      mem_wdata <= start_wdata;
      wait_cnt  <= '0;
    end else if (hit || timeout) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      wait_cnt <= '0;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/phase_responder.sv
// Phase responder: reacts to fetch/execute phase pulses from a timing
// generator, performs the memory access each phase calls for and reports
// completion with a one-cycle done pulse.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   T1_Mif, T2_Mif             fetch phase pulses (fetch, decode)
//   T1..T4, Mex                execute phase pulses, execute-cycle level
//   mem_req/we/addr/wdata      memory request (held until ack or timeout)
//   mem_rdata, mem_ack         memory response
//   done                       one-cycle phase-complete pulse
//   cnt_set, stop              decoded phase count code and halt request
//   ir, pc, acc                architectural registers
//   err                        sticky protocol error flag
module phase_responder
  import phase_responder_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 8,
  parameter int              ACK_TIMEOUT = 15,
  parameter logic [DATA_W-1:0] HALT_OP   = DATA_W'(HALT_OP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              T1_Mif,
  input  logic              T2_Mif,
  input  logic              T1,
  input  logic              T2,
  input  logic              T3,
  input  logic              T4,
  input  logic              Mex,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic [1:0]        cnt_set,
  output logic              stop,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              err
);

  state_t            state, next_state;
  op_t               op, sel_op;
  logic [ADDR_W-1:0] op_addr;   // operand address latched by a memory T1

  logic              accept, decode, pulse_err;
  logic              start, start_we;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_wdata;
  logic              hit, timeout;

  logic [5:0] raw;
  logic       multi;
  logic       is_mem, is_wr;

  assign raw    = {T1_Mif, T2_Mif, T1, T2, T3, T4};
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi  = |(raw & (raw - 6'd1));
  assign is_mem = ir[MEM_BIT];
  assign is_wr  = ir[WE_BIT];
  assign done   = (state == RESP);

  phase_responder_mem_port #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_mem_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_we   (start_we),
    .start_addr (start_addr),
    .start_wdata(start_wdata),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .hit        (hit),
    .timeout    (timeout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    sel_op      = OP_NONE;
    accept      = 1'b0;
    decode      = 1'b0;
    pulse_err   = 1'b0;
    start       = 1'b0;
    start_we    = 1'b0;
    start_addr  = pc;
    start_wdata = acc;
    case (state)
      IDLE: begin
        // Execute pulses outside an execute cycle are dropped but flagged.
        pulse_err = multi | (~Mex & (T1 | T2 | T3 | T4));
        if (T1_Mif) begin
          accept = 1'b1;
          sel_op = OP_FETCH;
          start  = 1'b1;
        end else if (T2_Mif) begin
          accept = 1'b1;
          decode = 1'b1;
        end else if (Mex && T1) begin
          accept = 1'b1;
          if (is_mem) begin
            sel_op = OP_OPERAND;
            start  = 1'b1;
          end
        end else if (Mex && T2) begin
          accept = 1'b1;
          if (is_mem) begin
            sel_op     = is_wr ? OP_DATA_WR : OP_DATA_RD;
            start      = 1'b1;
            start_we   = is_wr;
            start_addr = op_addr;
          end
        end else if (Mex && (T3 || T4)) begin
          accept = 1'b1;
        end
        if (accept) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        pulse_err = |raw;
        if (op == OP_NONE || hit || timeout) next_state = RESP;
      end
      RESP: begin
        pulse_err  = |raw;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= OP_NONE;
      op_addr <= '0;
      ir      <= '0;
      pc      <= '0;
      acc     <= '0;
      cnt_set <= 2'b00;
      stop    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (pulse_err || timeout) err <= 1'b1;
      if (accept) op <= sel_op;
      if (decode) begin
        cnt_set <= ir[CNT_HI:CNT_LO];
        stop    <= (ir == HALT_OP);
      end
      // A timeout leaves every architectural register untouched.
      if (state == MEM_WAIT && hit) begin
        case (op)
          OP_FETCH: begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
          OP_OPERAND: begin
            op_addr <= ADDR_W'(mem_rdata);
            pc      <= pc + ADDR_W'(1);
          end
          OP_DATA_RD: acc <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

endmodule
